// File: rtl/regfile_ctrl.sv
// Command sequencer in front of an 8-entry register file: reads the operands,
// runs the ALU and writes the result back through a READ/EXEC/WRITE sequence.
module regfile_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AW-1:0]    cmd_rd,
  input  logic [AW-1:0]    cmd_ra,
  input  logic [AW-1:0]    cmd_rb,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [AW-1:0]    rf_ra,
  output logic [AW-1:0]    rf_rb,
  output logic             rf_oeA,
  output logic             rf_oeB,
  input  logic [WIDTH-1:0] rf_a,
  input  logic [WIDTH-1:0] rf_b,
  output logic             rf_ld,
  output logic [AW-1:0]    rf_wa,
  output logic [WIDTH-1:0] rf_din,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             flag_z,
  output logic             flag_c
);

  localparam int unsigned SW = WIDTH + 1;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOADI = 3'd1;
  localparam logic [2:0] OP_MOV   = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_AND   = 3'd5;
  localparam logic [2:0] OP_OR    = 3'd6;
  localparam logic [2:0] OP_XOR   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW-1:0]    ra_q, ra_d;
  logic [AW-1:0]    rb_q, rb_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             flag_z_q, flag_z_d;
  logic             flag_c_q, flag_c_d;
  logic [WIDTH:0]   sum_c;
  logic             accept_c;

  assign sum_c    = SW'(a_q) + SW'(b_q);
  assign accept_c = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      res_data_q <= '0;
      flag_z_q   <= 1'b0;
      flag_c_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      res_data_q <= res_data_d;
      flag_z_q   <= flag_z_d;
      flag_c_q   <= flag_c_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    ra_d       = ra_q;
    rb_d       = rb_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    carry_d    = carry_q;
    res_data_d = res_data_q;
    flag_z_d   = flag_z_q;
    flag_c_d   = flag_c_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          case (cmd_op)
            OP_NOP: ;
            OP_LOADI: begin
              rd_d     = cmd_rd;
              result_d = cmd_imm;
              carry_d  = 1'b0;
              state_d  = S_WRITE;
            end
            default: begin
              // Read addresses only move for commands that actually read
              op_d    = cmd_op;
              rd_d    = cmd_rd;
              ra_d    = cmd_ra;
              rb_d    = cmd_rb;
              state_d = S_READ;
            end
          endcase
        end
      end
      S_READ: begin
        a_d     = rf_a;
        b_d     = rf_b;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        carry_d = 1'b0;
        case (op_q)
          OP_MOV: result_d = a_q;
          OP_ADD: {carry_d, result_d} = sum_c;
          OP_SUB: begin
            result_d = a_q - b_q;
            carry_d  = (a_q < b_q);
          end
          OP_AND:  result_d = a_q & b_q;
          OP_OR:   result_d = a_q | b_q;
          OP_XOR:  result_d = a_q ^ b_q;
          default: result_d = a_q;
        endcase
        state_d = S_WRITE;
      end
      S_WRITE: begin
        res_data_d = result_q;
        flag_z_d   = (result_q == '0);
        flag_c_d   = carry_q;
        state_d    = S_IDLE;
      end
    endcase
  end

  // Strobes are pure state decodes; data comes straight from registers
  assign cmd_ready = reset && (state_q == S_IDLE);
  assign rf_ra     = ra_q;
  assign rf_rb     = rb_q;
  assign rf_oeA    = (state_q == S_READ);
  assign rf_oeB    = (state_q == S_READ);
  assign rf_ld     = (state_q == S_WRITE);
  assign rf_wa     = rd_q;
  assign rf_din    = result_q;
  assign res_valid = (state_q == S_WRITE);
  assign res_data  = res_data_q;
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;

endmodule
